// File: rtl/t_ff_pkg.sv
// Shared constants for the t_ff toggle flip-flop bank.
package t_ff_pkg;
  localparam int unsigned T_FF_DEF_WIDTH = 1;
  localparam logic [T_FF_DEF_WIDTH-1:0] T_FF_DEF_RESET_VALUE = '0;
  localparam int unsigned T_FF_CNT_W = 16;
endpackage

// File: rtl/t_ff_if.sv
// Toggle request / state bundle for t_ff; toggle_cnt present only with T_FF_TOGGLE_CNT_EN.
interface t_ff_if
  import t_ff_pkg::*;
#(
  parameter int unsigned WIDTH = T_FF_DEF_WIDTH
);
  logic [WIDTH-1:0] T;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
`ifdef T_FF_TOGGLE_CNT_EN
  logic [T_FF_CNT_W-1:0] toggle_cnt;

  modport master (output T, input q, input q_n, input toggle_cnt);
  modport slave  (input T, output q, output q_n, output toggle_cnt);
`else
  modport master (output T, input q, input q_n);
  modport slave  (input T, output q, output q_n);
`endif
endinterface

// File: rtl/t_ff_cell.sv
// Single-bit T flip-flop with synchronous active-high reset to a per-bit value.
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic t,
  output logic q
);
  always_ff @(posedge clk) begin
    if (rst)
      q <= rst_val;
    else if (t)
      q <= ~q;
  end
endmodule

// File: rtl/t_ff.sv
// WIDTH independent toggle flip-flops; T_FF_TOGGLE_CNT_EN adds a 16-bit count of bit-0 toggles.
module t_ff
  import t_ff_pkg::*;
#(
  parameter int unsigned WIDTH = T_FF_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(T_FF_DEF_RESET_VALUE)
) (
  input  logic     clk,
  input  logic     rst,
  t_ff_if.slave    bus
);
  logic [WIDTH-1:0] q_r;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RESET_VALUE[i]),
      .t       (bus.T[i]),
      .q       (q_r[i])
    );
  end

  // q_n is derived from q so the two can never disagree, even around reset.
  assign bus.q   = q_r;
  assign bus.q_n = ~q_r;

`ifdef T_FF_TOGGLE_CNT_EN
  logic [T_FF_CNT_W-1:0] cnt_r;

  always_ff @(posedge clk) begin
    if (rst)
      cnt_r <= '0;
    else if (bus.T[0])
      cnt_r <= cnt_r + T_FF_CNT_W'(1);
  end

  assign bus.toggle_cnt = cnt_r;
`endif
endmodule

// File: tb/tb_t_ff.sv
// Directed scoreboard bench for t_ff: a 1-bit bank (reset 0) and a 4-bit bank (reset 4'b1010).
module tb_t_ff;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned fails  = 0;

  t_ff_if #(.WIDTH(1)) if1 ();
  t_ff_if #(.WIDTH(4)) if4 ();

  t_ff #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  t_ff #(.WIDTH(4), .RESET_VALUE(4'b1010)) u4 (.clk(clk), .rst(rst), .bus(if4));

  always #5 clk = ~clk;

  typedef struct {
    logic        e1;
    logic [3:0]  e4;
    logic [15:0] ec;
    string       tag;
  } exp_t;

  exp_t sb[$];

  logic        m1 = 1'b0;
  logic [3:0]  m4 = 4'b0000;
  logic [15:0] mc = 16'h0000;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus (called 1 ns after an edge), optionally glitch
  // T and rst between edges, then compare against the scoreboard after the edge.
  task automatic step(input string tag, input logic r, input logic t1,
                      input logic [3:0] t4, input bit glitch, input bit full);
    exp_t e;
    logic [3:0] p4;
    logic p1;
    p1 = m1;
    p4 = m4;
    rst = r;
    if1.T = t1;
    if4.T = t4;
    if (r) begin
      m1 = 1'b0;
      m4 = 4'b1010;
      mc = 16'h0000;
    end else begin
      m1 = m1 ^ t1;
      m4 = m4 ^ t4;
      if (t1) mc = mc + 16'h0001;
    end
    e.e1 = m1; e.e4 = m4; e.ec = mc; e.tag = tag;
    sb.push_back(e);
    if (glitch) begin
      #2;
      rst = ~r;
      if1.T = ~t1;
      if4.T = ~t4;
      #1;
      chk1({tag, "_glitch_q1"}, if1.q, p1);
      chk4({tag, "_glitch_q4"}, if4.q, p4);
      rst = r;
      if1.T = t1;
      if4.T = t4;
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (full) begin
      chk1({e.tag, "_q1"}, if1.q, e.e1);
      chk1({e.tag, "_qn1"}, if1.q_n, ~e.e1);
      chk4({e.tag, "_q4"}, if4.q, e.e4);
      chk4({e.tag, "_qn4"}, if4.q_n, ~e.e4);
    end
`ifdef T_FF_TOGGLE_CNT_EN
    if (full) chk16({e.tag, "_cnt"}, if1.toggle_cnt, e.ec);
`endif
  endtask

  initial begin
    if1.T = 1'b0;
    if4.T = 4'b0000;
    #1;
    step("por",        1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    step("hold",       1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    step("tog_a",      1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
    step("tog_b",      1'b0, 1'b1, 4'b0000, 1'b1, 1'b1);
    step("rst_wins",   1'b1, 1'b1, 4'b1111, 1'b0, 1'b1);
    step("resume",     1'b0, 1'b1, 4'b0011, 1'b0, 1'b1);
    step("rst_again",  1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    step("w4_0011",    1'b0, 1'b0, 4'b0011, 1'b0, 1'b1);
    step("w4_0100",    1'b0, 1'b1, 4'b0100, 1'b1, 1'b1);
    step("w4_1000",    1'b0, 1'b0, 4'b1000, 1'b0, 1'b1);
    step("w4_1111",    1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) begin
      step("rand", ($urandom_range(0, 7) == 0), 1'($urandom),
           4'($urandom), 1'($urandom), 1'b1);
    end
`ifdef T_FF_TOGGLE_CNT_EN
    step("cnt_rst", 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 65536; i++) begin
      step("cnt_run", 1'b0, 1'b1, 4'b0000, 1'b0, (i < 4) ? 1'b1 : 1'b0);
    end
    step("cnt_wrap", 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
`endif
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/t_ff.md
T_FF -- requirements
Module: t_ff

Interface
REQ-001 Parameter WIDTH, default 1, number of independent toggle bits.
REQ-002 Parameter RESET_VALUE, default all-zeros (WIDTH bits), value loaded into q on reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 T  input  WIDTH  toggle request per bit; 1 = invert that bit at the next rising clk.
REQ-006 q  output  WIDTH  registered flip-flop state.
REQ-007 q_n  output  WIDTH  bitwise complement of q; combinational from q, never independently registered.

Function
REQ-008 At each rising clk with rst=0: q[i] SHALL become ~q[i] when T[i]=1, and hold when T[i]=0.
REQ-009 Latency SHALL be exactly one clock edge from T being sampled to the q update; no combinational path from T to q.
REQ-010 T SHALL be sampled only at the rising clk; T changes between edges SHALL have no effect.
REQ-011 T held at 1 for N consecutive edges SHALL produce N toggles, so q has period 2 clocks per bit.
REQ-012 Bits SHALL be fully independent; toggling one bit SHALL never affect another.
REQ-013 q_n SHALL equal ~q at all times, including during and after reset.
REQ-014 Simultaneous rst=1 and T=1 at the same edge: reset SHALL win and q = RESET_VALUE.
REQ-015 A reset asserted mid-operation SHALL take effect at the next rising edge; the following edge with rst=0 SHALL resume toggling from RESET_VALUE.

Reset
REQ-016 Reset SHALL be synchronous and active-high: q = RESET_VALUE at any rising clk where rst=1.
REQ-017 Reset value of every output: q = RESET_VALUE, q_n = ~RESET_VALUE, toggle_cnt = 0 (when present).
REQ-018 Before the first reset edge, q is undefined; the bench SHALL NOT check it.
REQ-019 rst SHALL have no asynchronous effect; asserting it between edges changes nothing until the next edge.

Configuration
REQ-020 Macro T_FF_TOGGLE_CNT_EN defined: add output toggle_cnt [15:0], the count of edges at which bit 0 toggled (rst=0 and T[0]=1), wrapping from 16'hFFFF to 0, cleared by rst.
REQ-021 Macro T_FF_TOGGLE_CNT_EN undefined: no toggle_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-022 Package t_ff_pkg SHALL hold the default WIDTH, the default RESET_VALUE, and the toggle counter width constant (16).
REQ-023 One sub-module, t_ff_cell (1-bit T flip-flop with synchronous reset and reset-value input), SHALL be instantiated WIDTH times by a generate loop.
REQ-024 The toggle counter SHALL live in the top module t_ff, not in t_ff_cell.

Verification
REQ-025 Power-up: rst=1, T=0, clk period 10 ns, first edge at 5 ns -> q=0 and q_n=1 after the 5 ns edge.
REQ-026 Release rst at 7 ns with T=0 until 20 ns -> q holds 0 at the 15 ns edge.
REQ-027 T=1 from 20 ns to 40 ns -> q toggles at 25 ns (q=1) and at 35 ns (q=0).
REQ-028 rst=1 from 37 ns to 47 ns with T=1 -> q=0 at 45 ns despite T=1; toggling resumes at 55 ns (q=1 if T=1).
REQ-029 WIDTH=4, RESET_VALUE=4'b1010, T=4'b0011 for one edge after reset -> q=4'b1001, q_n=4'b0110.
REQ-030 With T_FF_TOGGLE_CNT_EN, hold T[0]=1 for 65537 edges after reset -> toggle_cnt=1 (wrapped) and q[0]=1.
